// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, register map and FSM state type for nn_host_if
package nn_pkg;

    localparam int N_PIX_DEF = 784;
    localparam int N_OUT_DEF = 10;

    // Byte offsets of the register window (bits [1:0] are ignored on the bus).
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_PIXEL  = 8'h08;
    localparam logic [7:0] REG_ARGMAX = 8'h0C;
    localparam logic [7:0] REG_RESULT = 8'h10;

    // CTRL write bits.
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    // STATUS read bit positions.
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } nn_state_t;

endpackage

// File: rtl/nn_pix_fifo.sv
// rtl/nn_pix_fifo.sv - pixel FIFO with first-word-fall-through output
// Ports: clk, reset (sync, active-low), push/wdata in, pop in, rdata = head word,
// full, empty, count (0..DEPTH). Push while full is legal only together with a pop.
module nn_pix_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_host_if.sv
// rtl/nn_host_if.sv - picoRV32 bus responder and stream master for the MNIST accelerator
// Ports: clk, reset (sync, active-low); mem_* native memory bus (responder);
// acc_start pulse, img_data/img_valid/img_ready pixel stream (master);
// res_data/res_valid score input; irq level while an inference is done.
module nn_host_if
    import nn_pkg::*;
#(
    parameter int N_PIX      = N_PIX_DEF,
    parameter int N_OUT      = N_OUT_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [7:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        acc_start,
    output logic [31:0] img_data,
    output logic        img_valid,
    input  logic        img_ready,
    input  logic [31:0] res_data,
    input  logic        res_valid,
    output logic        irq
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int RW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    nn_state_t state, next_state;

    logic [15:0]        pix_cnt;
    logic [15:0]        pushed_cnt;
    logic [RW-1:0]      res_cnt;
    logic signed [31:0] results [N_OUT];
    logic signed [31:0] max_val;
    logic signed [31:0] score;
    logic [3:0]         argmax;
    logic               done;
    logic               err;

    logic               fifo_full;
    logic               fifo_empty;
    logic [FAW:0]       fifo_count;

    logic [7:0]         reg_addr;
    logic               unused_addr_bits;
    logic               wr, req, busy, pop, push, res_take;
    logic               pix_wr, pix_drop, pix_stall, accept, ctrl_wr, go;
    logic [31:0]        rd_val;

    assign reg_addr         = {mem_addr[7:2], 2'b00};
    assign unused_addr_bits = ^mem_addr[1:0];
    assign score            = res_data;
    assign wr               = |mem_wstrb;
    // Once mem_ready is up the request has been served; don't take it twice.
    assign req              = mem_valid && !mem_ready;
    assign irq              = done;

    nn_pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (mem_wdata),
        .pop   (pop),
        .rdata (img_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        busy      = (state == S_STREAM) || (state == S_COLLECT);
        // Held off during the acc_start cycle so the first word follows the pulse.
        img_valid = (state == S_STREAM) && !fifo_empty && !acc_start;
        pop       = img_valid && img_ready;
        res_take  = (state == S_COLLECT) && res_valid;
        pix_wr    = req && wr && (reg_addr == REG_PIXEL);
        pix_drop  = pix_wr && (pushed_cnt >= 16'(N_PIX));
        // A full FIFO stalls the bus unless a word leaves in this same cycle.
        pix_stall = pix_wr && !pix_drop && fifo_full && !pop;
        accept    = req && !pix_stall;
        push      = accept && pix_wr && !pix_drop;
        ctrl_wr   = accept && wr && (reg_addr == REG_CTRL);
        go        = ctrl_wr && mem_wdata[CTRL_START] && !busy;

        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (go) next_state = S_STREAM;
            S_STREAM:       if (pop && (pix_cnt == 16'(N_PIX - 1))) next_state = S_COLLECT;
            S_COLLECT:      if (res_take && (res_cnt == RW'(N_OUT - 1))) next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            REG_STATUS: begin
                rd_val[ST_BUSY]          = busy;
                rd_val[ST_DONE]          = done;
                rd_val[ST_ERR]           = err;
                rd_val[ST_CNT_LSB +: 8]  = 8'(fifo_count);
            end
            REG_ARGMAX: rd_val[3:0] = argmax;
            default: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (reg_addr == REG_RESULT + 8'(4 * k)) begin
                        rd_val = results[k];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            acc_start  <= 1'b0;
            pix_cnt    <= '0;
            pushed_cnt <= '0;
            res_cnt    <= '0;
            max_val    <= '0;
            argmax     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                results[k] <= '0;
            end
        end else begin
            mem_ready <= accept;
            mem_rdata <= (accept && !wr) ? rd_val : '0;
            acc_start <= go;

            if (push) begin
                pushed_cnt <= pushed_cnt + 16'd1;
            end
            if (pix_drop) begin
                err <= 1'b1;
            end
            if (pop) begin
                pix_cnt <= pix_cnt + 16'd1;
            end

            if (res_take) begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (res_cnt == RW'(k)) begin
                        results[k] <= score;
                    end
                end
                // Class 0 seeds the maximum; strict compare keeps the lowest index on ties.
                if ((res_cnt == '0) || (score > max_val)) begin
                    max_val <= score;
                    argmax  <= 4'(res_cnt);
                end
                res_cnt <= res_cnt + 1'b1;
            end

            if (ctrl_wr && mem_wdata[CTRL_CLEAR]) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (ctrl_wr && mem_wdata[CTRL_START] && busy) begin
                err <= 1'b1;
            end
            if (go) begin
                pix_cnt    <= '0;
                pushed_cnt <= '0;
                res_cnt    <= '0;
                max_val    <= '0;
                argmax     <= '0;
                done       <= 1'b0;
            end
            if ((state == S_COLLECT) && (next_state == S_DONE)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nn_host_if.sv
// tb/tb_nn_host_if.sv - scoreboard bench for nn_host_if
module tb_nn_host_if;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_PIXEL  = 8'h08;
    localparam logic [7:0] A_ARGMAX = 8'h0C;
    localparam logic [7:0] A_RESULT = 8'h10;
    localparam int NP = 784;
    localparam int NO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        acc_start;
    logic [31:0] img_data;
    logic        img_valid;
    logic        img_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        irq;

    always #5 clk = ~clk;

    nn_host_if #(.N_PIX(NP), .N_OUT(NO), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .acc_start (acc_start),
        .img_data  (img_data),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .irq       (irq)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] pix_q [$];
    logic [31:0] obs_q [$];
    int          obs_idx  = 0;
    int          scores [NO];

    // Accelerator model state (written only by the model process).
    int   hs_cnt      = 0;
    int   acc_starts  = 0;
    int   overlap_cnt = 0;
    int   pulse_seen  = 0;
    logic tog         = 1'b0;
    // Written only by the main process.
    logic acc_en      = 1'b0;
    int   pulse_req   = 0;

    initial begin : acc_model
        img_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (acc_start === 1'b1) begin
                acc_starts++;
                if (img_valid === 1'b1) overlap_cnt++;
            end
            if (pulse_req != pulse_seen) begin
                img_ready  = 1'b1;
                pulse_seen = pulse_req;
            end else if (acc_en) begin
                img_ready = tog;
                tog       = !tog;
            end else begin
                img_ready = 1'b0;
            end
            if (img_valid === 1'b1 && img_ready) begin
                hs_cnt++;
                obs_q.push_back(img_data);
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic bus_xfer(input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata);
        int cyc;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        rdata     = '0;
        cyc       = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!mem_ready && cyc < 300);
        if (!mem_ready) begin
            n_checks++;
            $display("FAIL bus_timeout addr=%h got=no_ready want=ready", addr);
        end else begin
            rdata = mem_rdata;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] dummy;
        bus_xfer(addr, data, strb, dummy);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
        bus_xfer(addr, 32'h0, 4'h0, data);
    endtask

    task automatic push_pix(input logic [31:0] v, input int i);
        pix_q.push_back(v);
        bus_write(A_PIXEL, v, (i % 2 == 1) ? 4'h1 : 4'hF);
    endtask

    task automatic wait_hs(input int target);
        int cyc = 0;
        while (hs_cnt < target && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic send_scores(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            res_data  = scores[k];
            res_valid = 1'b1;
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            if (k != last) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic int calc_argmax();
        int best = 0;
        for (int k = 1; k < NO; k++) begin
            if (scores[k] > scores[best]) best = k;
        end
        return best;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_ready, acc_start, img_valid, irq} !== 4'b0 || mem_rdata !== 32'h0)
            $display("FAIL reset_outputs got=%b/%h want=0000/0", {mem_ready, acc_start, img_valid, irq}, mem_rdata);
        else n_pass++;
        reset = 1'b1;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_status got=%h want=0", d); else n_pass++;
        bus_read(A_ARGMAX, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_argmax got=%h want=0", d); else n_pass++;
        bus_read(A_RESULT + 8'd36, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_result9 got=%h want=0", d); else n_pass++;
    endtask

    task automatic test_full_inference();
        logic [31:0] d, e;
        int s0 = acc_starts;
        int h0 = hs_cnt;
        acc_en = 1'b1;
        bus_write(A_CTRL, 32'h1, 4'h1);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (acc_starts != s0 + 1) $display("FAIL full_acc_start got=%0d want=%0d", acc_starts - s0, 1); else n_pass++;
        for (int i = 0; i < NP; i++) push_pix(32'(i), i);
        wait_hs(h0 + NP);
        while (pix_q.size() > 0) begin
            e = pix_q.pop_front();
            n_checks++;
            if (obs_idx >= obs_q.size()) $display("FAIL full_img_word got=none want=%h", e);
            else if (obs_q[obs_idx] !== e) $display("FAIL full_img_word idx=%0d got=%h want=%h", obs_idx, obs_q[obs_idx], e);
            else n_pass++;
            obs_idx++;
        end
        n_checks++;
        if (hs_cnt - h0 != NP) $display("FAIL full_hs_count got=%0d want=%0d", hs_cnt - h0, NP); else n_pass++;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL full_status_collect got=%h want=00000001", d); else n_pass++;
        scores = '{5, -3, 9, 9, 0, 1, 2, 3, 4, -100};
        send_scores(0, NO - 2);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL full_irq_early got=%b want=0", irq); else n_pass++;
        send_scores(NO - 1, NO - 1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL full_irq_latency got=%b want=1", irq); else n_pass++;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h2) $display("FAIL full_status_done got=%h want=00000002", d); else n_pass++;
        bus_read(A_ARGMAX, d);
        n_checks++;
        if (d !== 32'(calc_argmax())) $display("FAIL full_argmax got=%0d want=%0d", d, calc_argmax()); else n_pass++;
        for (int k = 0; k < NO; k++) begin
            bus_read(A_RESULT + 8'(4 * k), d);
            n_checks++;
            if (d !== 32'(scores[k])) $display("FAIL full_result%0d got=%h want=%h", k, d, 32'(scores[k])); else n_pass++;
        end
        n_checks++;
        if (overlap_cnt != 0) $display("FAIL full_valid_with_start got=%0d want=0", overlap_cnt); else n_pass++;
    endtask

    task automatic test_backpressure_overpush();
        logic [31:0] d, e, v;
        logic wr_done;
        int h0;
        bus_write(A_CTRL, 32'h2, 4'hF);
        acc_en = 1'b0;
        h0 = hs_cnt;
        bus_write(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 16; i++) push_pix($urandom, i);
        bus_read(A_STATUS, d);
        n_checks++;
        if (d[15:8] !== 8'd16 || d[0] !== 1'b1) $display("FAIL bp_count_full got=%h want=00001001", d); else n_pass++;
        v = $urandom;
        pix_q.push_back(v);
        wr_done = 1'b0;
        fork
            begin
                bus_write(A_PIXEL, v, 4'hF);
                wr_done = 1'b1;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                n_checks++;
                if (wr_done !== 1'b0) $display("FAIL bp_ready_withheld got=%b want=0", wr_done); else n_pass++;
                pulse_req++;
            end
        join
        n_checks++;
        if (hs_cnt - h0 != 1) $display("FAIL bp_single_pop got=%0d want=1", hs_cnt - h0); else n_pass++;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d[15:8] !== 8'd16) $display("FAIL bp_count_after got=%0d want=16", d[15:8]); else n_pass++;
        acc_en = 1'b1;
        for (int i = 17; i < NP; i++) push_pix($urandom, i);
        bus_read(A_STATUS, d);
        n_checks++;
        if (d[2] !== 1'b0) $display("FAIL op_err_before got=%b want=0", d[2]); else n_pass++;
        bus_write(A_PIXEL, 32'hDEAD_BEEF, 4'hF);
        bus_read(A_STATUS, d);
        n_checks++;
        if (d[2] !== 1'b1) $display("FAIL op_err_after got=%b want=1", d[2]); else n_pass++;
        wait_hs(h0 + NP);
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (hs_cnt - h0 != NP) $display("FAIL op_hs_count got=%0d want=%0d", hs_cnt - h0, NP); else n_pass++;
        while (pix_q.size() > 0) begin
            e = pix_q.pop_front();
            n_checks++;
            if (obs_idx >= obs_q.size()) $display("FAIL op_img_word got=none want=%h", e);
            else if (obs_q[obs_idx] !== e) $display("FAIL op_img_word idx=%0d got=%h want=%h", obs_idx, obs_q[obs_idx], e);
            else n_pass++;
            obs_idx++;
        end
        for (int k = 0; k < NO; k++) scores[k] = -1;
        send_scores(0, NO - 1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL neg_irq got=%b want=1", irq); else n_pass++;
        bus_read(A_ARGMAX, d);
        n_checks++;
        if (d !== 32'(calc_argmax())) $display("FAIL neg_argmax got=%0d want=%0d", d, calc_argmax()); else n_pass++;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h6) $display("FAIL neg_status got=%h want=00000006", d); else n_pass++;
        bus_write(A_CTRL, 32'h2, 4'h1);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL clear_irq got=%b want=0", irq); else n_pass++;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL clear_status got=%h want=0", d); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        logic [31:0] d, e;
        int s0 = acc_starts;
        int h0 = hs_cnt;
        acc_en = 1'b1;
        bus_write(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 20; i++) push_pix($urandom, i);
        bus_write(A_CTRL, 32'h1, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (acc_starts - s0 != 1) $display("FAIL busy_acc_start got=%0d want=1", acc_starts - s0); else n_pass++;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d[2:0] !== 3'b101) $display("FAIL busy_status got=%b want=101", d[2:0]); else n_pass++;
        for (int i = 20; i < NP; i++) push_pix($urandom, i);
        wait_hs(h0 + NP);
        n_checks++;
        if (hs_cnt - h0 != NP) $display("FAIL busy_hs_count got=%0d want=%0d", hs_cnt - h0, NP); else n_pass++;
        while (pix_q.size() > 0) begin
            e = pix_q.pop_front();
            n_checks++;
            if (obs_idx >= obs_q.size()) $display("FAIL busy_img_word got=none want=%h", e);
            else if (obs_q[obs_idx] !== e) $display("FAIL busy_img_word idx=%0d got=%h want=%h", obs_idx, obs_q[obs_idx], e);
            else n_pass++;
            obs_idx++;
        end
        scores = '{3, -2, 7, 7, 1, -5, 7, 2, 6, 4};
        send_scores(0, NO - 1);
        bus_read(A_ARGMAX, d);
        n_checks++;
        if (d !== 32'(calc_argmax())) $display("FAIL busy_argmax got=%0d want=%0d", d, calc_argmax()); else n_pass++;
        for (int k = 0; k < NO; k++) begin
            bus_read(A_RESULT + 8'(4 * k), d);
            n_checks++;
            if (d !== 32'(scores[k])) $display("FAIL busy_result%0d got=%h want=%h", k, d, 32'(scores[k])); else n_pass++;
        end
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h6) $display("FAIL busy_status_end got=%h want=00000006", d); else n_pass++;
    endtask

    task automatic test_reset_collect();
        logic [31:0] d;
        int h0 = hs_cnt;
        bus_write(A_CTRL, 32'h2, 4'hF);
        acc_en = 1'b1;
        bus_write(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < NP; i++) push_pix($urandom, i);
        wait_hs(h0 + NP);
        n_checks++;
        if (hs_cnt - h0 != NP) $display("FAIL rst_hs_count got=%0d want=%0d", hs_cnt - h0, NP); else n_pass++;
        pix_q.delete();
        obs_idx = obs_q.size();
        scores = '{11, 12, 13, 14, 0, 0, 0, 0, 0, 0};
        send_scores(0, 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({mem_ready, acc_start, img_valid, irq} !== 4'b0 || mem_rdata !== 32'h0)
            $display("FAIL rst_outputs got=%b/%h want=0000/0", {mem_ready, acc_start, img_valid, irq}, mem_rdata);
        else n_pass++;
        reset = 1'b1;
        bus_read(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL rst_status got=%h want=0", d); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            bus_read(A_RESULT + 8'(4 * k), d);
            n_checks++;
            if (d !== 32'h0) $display("FAIL rst_result%0d got=%h want=0", k, d); else n_pass++;
        end
        bus_read(A_ARGMAX, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL rst_argmax got=%h want=0", d); else n_pass++;
    endtask

    initial begin
        reset     = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 8'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        res_data  = 32'h0;
        res_valid = 1'b0;
        test_reset();
        test_full_inference();
        test_backpressure_overpush();
        test_start_while_busy();
        test_reset_collect();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nn_host_if.md
# nn_host_if

Bus-side responder and stream master that drives the MNIST accelerator from the picoRV32 native memory interface. Firmware writes pixel words into a small FIFO, and the block streams them to the accelerator's image input. It then collects the ten class scores the accelerator returns and computes the argmax. Results and status are exposed as memory-mapped registers, with a done interrupt.

## Interface
- `N_PIX`, default 784: image words per inference.
- `N_OUT`, default 10: result words per inference.
- `FIFO_DEPTH`, default 16: pixel FIFO entries, power of two.
- `clk`  in  1: single clock; all logic rising-edge.
- `reset`  in  1: synchronous, active-low; reset takes effect on the clock edge where `reset`=0.
- `mem_valid`  in  1: bus request.
- `mem_ready`  out  1: one-cycle completion pulse.
- `mem_addr`  in  8: byte offset; bits [1:0] ignored.
- `mem_wdata`  in  32: write data.
- `mem_wstrb`  in  4: nonzero = write, zero = read; partial strobes are treated as full-word writes.
- `mem_rdata`  out  32: read data, valid while `mem_ready`=1.
- `acc_start`  out  1: one-cycle pulse that begins an inference.
- `img_data`  out  32: pixel word.
- `img_valid`  out  1: `img_data` valid.
- `img_ready`  in  1: accelerator accepts the word.
- `res_data`  in  32: signed class score.
- `res_valid`  in  1: one score per pulse, in class order 0..`N_OUT`-1.
- `irq`  out  1: level; high while `done`=1.

## Operation
- Register map:
  - 0x00 CTRL (W): bit0 = start, bit1 = clear done/err.
  - 0x04 STATUS (R): bit0 busy, bit1 done, bit2 err, bits[15:8] FIFO count.
  - 0x08 PIXEL (W): push into FIFO.
  - 0x0C ARGMAX (R): bits[3:0].
  - 0x10 + 4k RESULT[k] (R): k = 0..`N_OUT`-1.
  - Other addresses read 0; writes to them are ignored.
- FSM states and transitions:
  - IDLE: on a start write, pulse `acc_start`, clear the pixel and result counters and the argmax state, then go to STREAM.
  - STREAM: `img_valid` = FIFO not empty; on each `img_valid`&&`img_ready`, pop and increment pix_cnt. When the `N_PIX`-th word transfers, go to COLLECT.
  - COLLECT: on each `res_valid`, store `res_data` to RESULT[res_cnt], update the argmax and increment res_cnt. After the `N_OUT`-th score, go to DONE and set `done`.
  - DONE: behaves as IDLE for start, and a new start clears `done`.
- Argmax rule: signed 32-bit compare, strict greater-than, so ties keep the lowest index. Class 0 is initialised as the maximum.
- PIXEL writes are accepted in any state. A write that would push the total pushed this inference beyond `N_PIX` is dropped and sets `err`. Total pushed resets on start.
- A start write while busy (STREAM/COLLECT) is ignored and sets `err`.
- `res_valid` outside COLLECT is ignored.
- `err` and `done` are sticky until a clear write or reset.
- `img_data`/`img_valid` must hold stable while `img_valid`=1 and `img_ready`=0.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `acc_start`=0, `img_valid`=0, `irq`=0.
  - FIFO empty, all counters 0, RESULT[*]=0, ARGMAX=0, state IDLE.
- Reset mid-inference aborts it and discards FIFO contents; the accelerator is not notified.
- Bus latency:
  - Reads and non-PIXEL writes: `mem_ready` rises the cycle after `mem_valid` is sampled and stays high for exactly one cycle.
  - `mem_valid` must stay high until `mem_ready`.
- PIXEL write with FIFO full: `mem_ready` is withheld until an entry frees. The push and `mem_ready` then occur in the same cycle, so there is no data loss.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- Simultaneous push-when-full and pop: the push proceeds.
- `acc_start` asserts the cycle after the start write is accepted.
- `img_valid` can first assert one cycle after `acc_start`.
- Last score to `done`/`irq` high: 1 cycle. ARGMAX and RESULT are final when `done` is read as 1.
- A STATUS read in the same cycle as a state change returns the pre-change value.

## Structure
- `nn_pkg`: register offsets, the `N_PIX`/`N_OUT` defaults, the FSM state enum, and STATUS bit positions.
- Sub-module `nn_pix_fifo`: synchronous FIFO with push, pop, full, empty and count, and first-word-fall-through output.
- Top holds the FSM, register decode, result file and argmax.

## Test plan
- Full inference: push 784 words with value i; accelerator model accepts each word with one cycle of `img_ready`=0 in between, then returns scores {5,-3,9,9,0,1,2,3,4,-100} -> ARGMAX=2, RESULT[3]=9, `done`=1, `irq`=1.
- FIFO back-pressure: hold `img_ready`=0 and write 17 pixels -> 17th `mem_ready` withheld until `img_ready` pulses once, FIFO count 16 -> 16.
- Over-push: write 785 pixels -> 785th dropped, `err`=1, exactly 784 `img_valid`&&`img_ready` handshakes.
- Start while busy: second CTRL start during STREAM -> no second `acc_start`, `err`=1, inference completes normally.
- All-negative scores {-1,-1,...,-1} -> ARGMAX=0; then a clear write -> `done`=0, `err`=0, `irq`=0.
- Reset asserted in COLLECT after 4 scores -> all outputs at reset values next cycle, STATUS=0, RESULT[0..3] read 0.
